ssd_mux: RTL and testbench

Parametrised time-multiplexed seven-segment display driver for the board's common-anode digit banks. It scans NUM_DIGITS hex digits at a programmable refresh rate and adds features the first-generation driver lacks: per-frame value snapshot (no tearing), per-digit decimal points and blanking, leading-zero suppression, anode dead time against ghosting, and PWM brightness. It sits between application logic (value source) and the top-level pin outputs.

---
 rtl/ssd_pkg.sv | 22 ++
 rtl/ssd_mux_if.sv | 27 ++
 rtl/ssd_mux_seg_decode.sv | 29 ++
 rtl/ssd_mux.sv | 122 ++++++++++++
 tb/tb_ssd_mux.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-high {g,f,e,d,c,b,a} patterns for hex digits.
package ssd_pkg;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;
  localparam seg_t SEG_0   = 7'h3F;
  localparam seg_t SEG_1   = 7'h06;
  localparam seg_t SEG_2   = 7'h5B;
  localparam seg_t SEG_3   = 7'h4F;
  localparam seg_t SEG_4   = 7'h66;
  localparam seg_t SEG_5   = 7'h6D;
  localparam seg_t SEG_6   = 7'h7D;
  localparam seg_t SEG_7   = 7'h07;
  localparam seg_t SEG_8   = 7'h7F;
  localparam seg_t SEG_9   = 7'h6F;
  localparam seg_t SEG_A   = 7'h77;
  localparam seg_t SEG_B   = 7'h7C;
  localparam seg_t SEG_C   = 7'h39;
  localparam seg_t SEG_D   = 7'h5E;
  localparam seg_t SEG_E   = 7'h79;
  localparam seg_t SEG_F   = 7'h71;
endpackage

// File: rtl/ssd_mux_if.sv
// Value-source / pin-side bundle for the multiplexed seven-segment driver.
interface ssd_mux_if
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned BRIGHT_W   = 4
);
  logic [4*NUM_DIGITS-1:0] val_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    lz_en_in;
  logic [BRIGHT_W-1:0]     brightness_in;
  seg_t                    cat_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_out;

  modport master (
    output val_in, dp_in, blank_in, lz_en_in, brightness_in,
    input  cat_out, dp_out, an_out, frame_out
  );

  modport slave (
    input  val_in, dp_in, blank_in, lz_en_in, brightness_in,
    output cat_out, dp_out, an_out, frame_out
  );
endinterface

// File: rtl/ssd_mux_seg_decode.sv
// Combinational hex nibble to active-high segment pattern decoder.
module seg_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);
  always_comb begin
    seg = SEG_OFF;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end
endmodule

// File: rtl/ssd_mux.sv
// Time-multiplexed common-anode display scanner with frame snapshot, leading-zero
// suppression, anode dead time and PWM brightness. All pin outputs are registered.
module ssd_mux
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned COUNT_TO    = 1000,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned BRIGHT_W    = 4
)(
  input  logic      clk_in,
  input  logic      rst_in,
  ssd_mux_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(COUNT_TO + 1);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]        slot_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [BRIGHT_W-1:0]     pwm_cnt;
  logic [4*NUM_DIGITS-1:0] snap_val;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic                    snap_lz;

  logic                    frame_start;
  logic [4*NUM_DIGITS-1:0] cur_val;
  logic [NUM_DIGITS-1:0]   cur_dp;
  logic [NUM_DIGITS-1:0]   cur_blank;
  logic                    cur_lz;
  logic [NUM_DIGITS-1:0]   supp_mask;
  logic [3:0]              nibble;
  seg_t                    seg;
  logic                    digit_en;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_next;
  seg_t                    cat_next;
  logic                    dp_next;

  assign frame_start = (slot_cnt == '0) && (digit_idx == '0);

  // On the frame-start cycle the snapshot registers are still loading, so the
  // live inputs stand in for them; this keeps the whole frame on one value.
  always_comb begin
    cur_val   = frame_start ? bus.val_in   : snap_val;
    cur_dp    = frame_start ? bus.dp_in    : snap_dp;
    cur_blank = frame_start ? bus.blank_in : snap_blank;
    cur_lz    = frame_start ? bus.lz_en_in : snap_lz;
  end

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    supp_mask  = '0;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above   = zero_above & (cur_val[4*k +: 4] == 4'h0);
      supp_mask[k] = cur_lz & zero_above;
    end
  end

  assign nibble = cur_val[{digit_idx, 2'b00} +: 4];

  seg_decode u_dec (
    .nibble (nibble),
    .seg    (seg)
  );

  assign digit_en = (slot_cnt >= CNT_W'(DEAD_CYCLES)) &&
                    ((&bus.brightness_in) || (pwm_cnt < bus.brightness_in));
  assign lit      = digit_en && !cur_blank[digit_idx];

  always_comb begin
    an_next  = '1;
    cat_next = ~SEG_OFF;
    dp_next  = 1'b1;
    if (lit) begin
      an_next[digit_idx] = 1'b0;
      cat_next           = supp_mask[digit_idx] ? ~SEG_OFF : ~seg;
      dp_next            = ~cur_dp[digit_idx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      pwm_cnt    <= '0;
      snap_val   <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      snap_lz    <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (slot_cnt == CNT_W'(COUNT_TO)) begin
        slot_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (frame_start) begin
        snap_val   <= bus.val_in;
        snap_dp    <= bus.dp_in;
        snap_blank <= bus.blank_in;
        snap_lz    <= bus.lz_en_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      bus.an_out    <= '1;
      bus.cat_out   <= ~SEG_OFF;
      bus.dp_out    <= 1'b1;
      bus.frame_out <= 1'b0;
    end else begin
      bus.an_out    <= an_next;
      bus.cat_out   <= cat_next;
      bus.dp_out    <= dp_next;
      bus.frame_out <= frame_start;
    end
  end
endmodule

// File: tb/tb_ssd_mux.sv
// Self-checking bench for ssd_mux: vector table, scan corner sequences and a
// randomized run against a frame/slot arithmetic reference model.
module tb_ssd_mux;
  localparam int unsigned ND    = 4;
  localparam int unsigned CT    = 3;
  localparam int unsigned DC    = 1;
  localparam int unsigned BW    = 4;
  localparam int unsigned SLOT  = CT + 1;
  localparam int unsigned FRAME = ND * SLOT;

  logic clk_in = 1'b0;
  logic rst_in;

  ssd_mux_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

  ssd_mux #(
    .NUM_DIGITS  (ND),
    .COUNT_TO    (CT),
    .DEAD_CYCLES (DC),
    .BRIGHT_W    (BW)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [6:0] hex_tbl [16];

  // reference model state
  int unsigned cyc;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_blank;
  logic        m_lz;
  logic [3:0]  e_an;
  logic [6:0]  e_cat;
  logic        e_dp, e_frame;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
    logic [3:0]  bright;
    logic [1:0]  digit;
    logic [3:0]  exp_an;
    logic [6:0]  exp_cat;
    logic        exp_dp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the cycle about to be clocked, from frame/slot arithmetic.
  task automatic predict();
    int unsigned digit, slot, pwm;
    logic en, lit, supp;
    logic [3:0] nib;
    if (!rst_in) begin
      e_an = 4'hF; e_cat = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
      cyc = 0;
      return;
    end
    if (cyc % FRAME == 0) begin
      m_val = bus.val_in; m_dp = bus.dp_in; m_blank = bus.blank_in; m_lz = bus.lz_en_in;
    end
    digit = (cyc / SLOT) % ND;
    slot  = cyc % SLOT;
    pwm   = cyc % (1 << BW);
    en    = (slot >= DC) && (bus.brightness_in == 4'hF || pwm < bus.brightness_in);
    lit   = en && !m_blank[digit];
    nib   = 4'((m_val >> (4 * digit)) & 16'hF);
    supp  = m_lz && digit != 0 && (m_val >> (4 * digit)) == 16'h0;
    e_an    = lit ? ~(4'b0001 << digit) : 4'hF;
    e_cat   = (!lit || supp) ? 7'h7F : ~hex_tbl[nib];
    e_dp    = lit ? ~m_dp[digit] : 1'b1;
    e_frame = (cyc % FRAME == 0);
    cyc++;
  endtask

  task automatic cycle();
    predict();
    @(posedge clk_in);
    @(negedge clk_in);
    check("an", 16'(bus.an_out), 16'(e_an));
    check("frame", 16'(bus.frame_out), 16'(e_frame));
    if (e_an != 4'hF) begin
      check("cat", 16'(bus.cat_out), 16'(e_cat));
      check("dp", 16'(bus.dp_out), 16'(e_dp));
    end
  endtask

  task automatic run_to(input int unsigned t);
    while (cyc <= t) cycle();
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    cycle();
    rst_in = 1'b1;
  endtask

  task automatic set_in(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                        input logic lz, input logic [3:0] br);
    bus.val_in = v; bus.dp_in = dp; bus.blank_in = bl; bus.lz_en_in = lz; bus.brightness_in = br;
  endtask

  initial begin
    hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    cyc = 0;
    rst_in = 1'b0;
    set_in(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF);

    // reset state
    cycle();
    check("rst_an", 16'(bus.an_out), 16'hF);
    check("rst_cat", 16'(bus.cat_out), 16'h7F);
    check("rst_dp", 16'(bus.dp_out), 16'h1);
    check("rst_frame", 16'(bus.frame_out), 16'h0);

    //             val      dp    blank lz  br    dg  an    cat    dp
    vecs.push_back('{16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 2'd0, 4'hE, 7'h19, 1'b1});
    vecs.push_back('{16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 2'd1, 4'hD, 7'h30, 1'b1});
    vecs.push_back('{16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 2'd2, 4'hB, 7'h24, 1'b1});
    vecs.push_back('{16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, 2'd3, 4'h7, 7'h79, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, 2'd3, 4'h7, 7'h7F, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, 2'd2, 4'hB, 7'h7F, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, 2'd1, 4'hD, 7'h12, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, 2'd0, 4'hE, 7'h40, 1'b1});
    vecs.push_back('{16'h0050, 4'h0, 4'h0, 1'b0, 4'hF, 2'd3, 4'h7, 7'h40, 1'b1});
    vecs.push_back('{16'h0050, 4'h8, 4'h0, 1'b1, 4'hF, 2'd3, 4'h7, 7'h7F, 1'b0});
    vecs.push_back('{16'h0000, 4'h0, 4'h0, 1'b1, 4'hF, 2'd0, 4'hE, 7'h40, 1'b1});
    vecs.push_back('{16'h0000, 4'h0, 4'h0, 1'b1, 4'hF, 2'd1, 4'hD, 7'h7F, 1'b1});
    vecs.push_back('{16'h1234, 4'h1, 4'h2, 1'b0, 4'hF, 2'd1, 4'hF, 7'h7F, 1'b1});
    vecs.push_back('{16'h1234, 4'h1, 4'h2, 1'b0, 4'hF, 2'd0, 4'hE, 7'h19, 1'b0});
    vecs.push_back('{16'h1234, 4'h1, 4'h2, 1'b0, 4'hF, 2'd2, 4'hB, 7'h24, 1'b1});
    vecs.push_back('{16'hABCD, 4'h0, 4'h0, 1'b0, 4'hF, 2'd0, 4'hE, 7'h21, 1'b1});
    vecs.push_back('{16'hABCD, 4'h0, 4'h0, 1'b0, 4'hF, 2'd3, 4'h7, 7'h08, 1'b1});
    vecs.push_back('{16'h1234, 4'h0, 4'h0, 1'b0, 4'd4, 2'd0, 4'hE, 7'h19, 1'b1});
    vecs.push_back('{16'h1234, 4'h0, 4'h0, 1'b0, 4'd4, 2'd1, 4'hF, 7'h7F, 1'b1});
    vecs.push_back('{16'h1234, 4'h0, 4'h0, 1'b0, 4'd0, 2'd0, 4'hF, 7'h7F, 1'b1});

    foreach (vecs[i]) begin
      set_in(vecs[i].val, vecs[i].dp, vecs[i].blank, vecs[i].lz, vecs[i].bright);
      do_reset();
      run_to(int'(vecs[i].digit) * SLOT + 2);
      check("tbl_an", 16'(bus.an_out), 16'(vecs[i].exp_an));
      if (vecs[i].exp_an != 4'hF) begin
        check("tbl_cat", 16'(bus.cat_out), 16'(vecs[i].exp_cat));
        check("tbl_dp", 16'(bus.dp_out), 16'(vecs[i].exp_dp));
      end
    end

    // value change mid-frame is held off until the next frame
    set_in(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF);
    do_reset();
    run_to(9);
    bus.val_in = 16'hABCD;
    run_to(14);
    check("tear_old", 16'(bus.cat_out), 16'h79);
    run_to(FRAME + 14);
    check("tear_new", 16'(bus.cat_out), 16'h08);

    // first cycle after release, dead time, frame period
    set_in(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF);
    do_reset();
    cycle();
    check("fs_frame", 16'(bus.frame_out), 16'h1);
    check("dead_an", 16'(bus.an_out), 16'hF);
    cycle();
    check("dead_end_an", 16'(bus.an_out), 16'hE);
    run_to(FRAME - 1);
    check("frame_gap", 16'(bus.frame_out), 16'h0);
    cycle();
    check("frame_next", 16'(bus.frame_out), 16'h1);

    // reset mid-frame, restart at digit 0 with a fresh snapshot
    run_to(FRAME + 9);
    rst_in = 1'b0;
    cycle();
    check("mid_rst_an", 16'(bus.an_out), 16'hF);
    check("mid_rst_cat", 16'(bus.cat_out), 16'h7F);
    check("mid_rst_dp", 16'(bus.dp_out), 16'h1);
    bus.val_in = 16'h5678;
    rst_in = 1'b1;
    cycle();
    check("restart_frame", 16'(bus.frame_out), 16'h1);
    run_to(2);
    check("restart_an", 16'(bus.an_out), 16'hE);
    check("restart_cat", 16'(bus.cat_out), 16'h00);

    // randomized run against the model
    for (int i = 0; i < 1600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.val_in   = 16'($urandom) >> $urandom_range(0, 16);
        bus.dp_in    = 4'($urandom);
        bus.blank_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        bus.lz_en_in = 1'($urandom);
      end
      if ($urandom_range(0, 39) == 0)
        bus.brightness_in = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      rst_in = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
